// File: rtl/parity_frame_ctrl.sv
// Frame sequencer for a serial parity link: start, LSB-first data, parity, stop.
// Define PARITY_FRAME_ERR_CNT_EN to add a saturating error counter output err_cnt.
module parity_frame_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 x_vld,
  input  logic                 par_mode,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done,
  output logic                 par_err,
  output logic                 stop_err,
  output logic                 busy
`ifdef PARITY_FRAME_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]     err_cnt
`endif
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);

  if (DATA_BITS < 1 || DATA_BITS > 32) begin : g_bad_data_bits
    $error("parity_frame_ctrl: DATA_BITS must be within 1..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("parity_frame_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt;
  logic                   acc;
  logic                   mode;
  logic                   par_res;
  logic [DATA_BITS-1:0]   shreg;
  logic                   complete;
  logic                   busy_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (x_vld) begin
      case (state)
        IDLE:    if (!x) state_next = DATA;
        DATA:    if (cnt == LAST_IDX) state_next = PAR;
        PAR:     state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    complete  = x_vld && (state == STOP);
    busy_next = (state_next != IDLE);
  end

  // Datapath: the stop-bit edge publishes the word and status, which then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= 1'b0;
      mode     <= 1'b0;
      par_res  <= 1'b0;
      shreg    <= '0;
      data_out <= '0;
      done     <= 1'b0;
      par_err  <= 1'b0;
      stop_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= complete;
      busy <= busy_next;
      if (x_vld) begin
        case (state)
          IDLE: if (!x) begin
            cnt  <= '0;
            acc  <= 1'b0;
            mode <= par_mode;
          end
          DATA: begin
            shreg[cnt] <= x;
            acc        <= acc ^ x;
            cnt        <= cnt + 1'b1;
          end
          PAR: par_res <= acc ^ x ^ mode;
          STOP: begin
            data_out <= shreg;
            par_err  <= par_res;
            stop_err <= !x;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PARITY_FRAME_ERR_CNT_EN
  // Counts frames with any error and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (complete && (par_res || !x) && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl against a frame-level reference model.
module tb_parity_frame_ctrl;

  localparam int DB = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          x;
  logic          x_vld;
  logic          par_mode;
  logic [DB-1:0] data_out;
  logic          done;
  logic          par_err;
  logic          stop_err;
  logic          busy;
`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [CW-1:0] err_cnt;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DB-1:0] exp_data = '0;
  logic          exp_perr = 1'b0;
  logic          exp_serr = 1'b0;
  int            exp_errs = 0;

  parity_frame_ctrl #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .x_vld    (x_vld),
    .par_mode (par_mode),
    .data_out (data_out),
    .done     (done),
    .par_err  (par_err),
    .stop_err (stop_err),
    .busy     (busy)
`ifdef PARITY_FRAME_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".data"}, 32'(data_out), 32'(exp_data));
    check({tag, ".perr"}, 32'(par_err), 32'(exp_perr));
    check({tag, ".serr"}, 32'(stop_err), 32'(exp_serr));
`ifdef PARITY_FRAME_ERR_CNT_EN
    check({tag, ".errcnt"}, 32'(err_cnt), 32'(exp_errs));
`endif
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      x_vld    = 1'($urandom);
      x        = x_vld ? 1'b1 : 1'($urandom);
      par_mode = 1'($urandom);
      tick();
      check("idle.busy", 32'(busy), 32'd0);
      check_held("idle");
    end
  endtask

  // Sends one frame; par_mode is inverted on every bit after the start bit.
  task automatic send_frame(input logic [DB-1:0] word, input logic pbit, input logic sbit,
                            input logic mode, input int gap_min, input int gap_max);
    logic bits [DB+3];
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[i+1] = word[i];
    bits[DB+1] = pbit;
    bits[DB+2] = sbit;
    for (int i = 0; i < DB + 3; i++) begin
      int gap = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gap; g++) begin
        x_vld    = 1'b0;
        x        = 1'($urandom);
        par_mode = 1'($urandom);
        tick();
        check("gap.busy", 32'(busy), (i > 0) ? 32'd1 : 32'd0);
        check_held("gap");
      end
      x_vld    = 1'b1;
      x        = bits[i];
      par_mode = (i == 0) ? mode : ~mode;
      tick();
      if (i == DB + 2) begin
        exp_data = word;
        exp_perr = ^{word, pbit, mode};
        exp_serr = !sbit;
        if ((exp_perr || exp_serr) && exp_errs < (2**CW - 1)) exp_errs++;
        check("end.done", 32'(done), 32'd1);
        check("end.busy", 32'(busy), 32'd0);
        check("end.data", 32'(data_out), 32'(exp_data));
        check("end.perr", 32'(par_err), 32'(exp_perr));
        check("end.serr", 32'(stop_err), 32'(exp_serr));
`ifdef PARITY_FRAME_ERR_CNT_EN
        check("end.errcnt", 32'(err_cnt), 32'(exp_errs));
`endif
      end else begin
        check("bit.busy", 32'(busy), 32'd1);
        check_held("bit");
      end
    end
    x_vld = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    x        = 1'b1;
    x_vld    = 1'b0;
    par_mode = 1'b0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 32'd0);
    check_held("rst");
    rst = 1'b0;
    idle_ticks(2);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, 0);
    idle_ticks(1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0, 0);
    idle_ticks(1);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0, 0);
    idle_ticks(1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1, 1);
    idle_ticks(2);

    // Abort a frame after four data bits; reset wins over a valid sample.
    x_vld = 1'b1;
    x     = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      x = 1'($urandom);
      tick();
    end
    rst   = 1'b1;
    x     = 1'b1;
    tick();
    rst      = 1'b0;
    x_vld    = 1'b0;
    exp_data = '0;
    exp_perr = 1'b0;
    exp_serr = 1'b0;
    exp_errs = 0;
    check("abort.busy", 32'(busy), 32'd0);
    check_held("abort");
    idle_ticks(3);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 0, 0);
    idle_ticks(1);

`ifdef PARITY_FRAME_ERR_CNT_EN
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0, 0);
      check("sat.seq", 32'(err_cnt), (k < 3) ? 32'(k) : 32'd3);
    end
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, 0);
    check("sat.good", 32'(err_cnt), 32'd3);
    idle_ticks(1);
`endif

    for (int n = 0; n < 25; n++) begin
      send_frame(8'($urandom), 1'($urandom), ($urandom_range(3, 0) != 0), 1'($urandom), 0, 3);
      idle_ticks($urandom_range(2, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
